shift_reg_serializer: RTL and testbench
=======================================

Name: shift_reg_serializer

Overview:
Parametrised parallel-in/serial-out shift register with valid/ready handshakes on both sides. It is the next generation of the single-bit PISO shift register. It adds:
- a configurable lane width (LANES bits per beat)
- run-time LSB-first or MSB-first ordering
- a frame marker
- back-to-back word streaming with no bubble

It sits between a word-wide producer and a narrow serial link or downstream stage.

Parameters:
WIDTH, 8, parallel word width in bits.
LANES, 1, bits emitted per beat; WIDTH % LANES must be 0, otherwise $error at elaboration.
CNT_W, 16, width of the words_sent counter.

Ports:
clk  input  1  clock, all logic on posedge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  block accepts a word this cycle.
in_data  input  WIDTH  parallel word.
msb_first  input  1  order for the word being accepted; sampled only at accept.
ser_valid  output  1  ser_data holds a valid beat.
ser_ready  input  1  consumer accepts the beat.
ser_data  output  LANES  current beat.
ser_last  output  1  current beat is the final beat of its word.
busy  output  1  a word is in flight (state SHIFT).
words_sent  output  CNT_W  count of completed words; wraps modulo 2^CNT_W.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
  - While rst is high at a posedge, the block clears all state:
    - state = IDLE, ser_valid = 0, ser_data = 0, ser_last = 0, busy = 0
    - shift register = 0, beat counter = 0, words_sent = 0
  - in_ready is forced to 0 while rst = 1.
  - Reset mid-word discards the word; no further beats of it appear.
- Definitions:
  - BEATS = WIDTH/LANES.
  - in_fire = in_valid && in_ready.
  - ser_fire = ser_valid && ser_ready.
- States:
  - IDLE: ser_valid = 0, in_ready = 1.
  - SHIFT: ser_valid = 1. in_ready = ser_fire && ser_last. This is a combinational path from ser_ready and permits zero-bubble streaming.
- Transitions:
  - IDLE -> SHIFT on in_fire.
  - SHIFT -> SHIFT on ser_fire && ser_last && in_fire (next word loaded in the same edge).
  - SHIFT -> IDLE on ser_fire && ser_last && !in_fire.
  - Otherwise the block holds its state.
- On in_fire:
  - shift register <= in_data
  - mode bit <= msb_first
  - beat counter <= 0
  - ser_valid is high in the next cycle.
  - Latency from accept edge to first beat presented: 1 cycle.
- Beat selection:
  - LSB-first: ser_data = sreg[LANES-1:0]. On ser_fire (non-last), sreg shifts right by LANES with zero fill.
  - MSB-first: ser_data = sreg[WIDTH-1 -: LANES]. On ser_fire (non-last), sreg shifts left by LANES with zero fill.
- ser_last = (beat counter == BEATS-1) while in SHIFT. When LANES == WIDTH, every beat is last.
- Stall: while ser_valid && !ser_ready, ser_data, ser_last and all state stay stable. in_ready = 0 in this case.
- words_sent increments by 1 on every ser_fire && ser_last, and wraps from all-ones to 0.
- msb_first changes during a word have no effect on that word.
- in_data is not required to be held after accept.

Test Plan:
- Order check, WIDTH=8, LANES=1, LSB-first: load 0xB4 with ser_ready=1 -> ser_data sequence 0,0,1,0,1,1,0,1 on 8 consecutive cycles starting 1 cycle after accept. ser_last only on the 8th beat. Then busy=0, words_sent=1.
- Order check, WIDTH=8, LANES=1, MSB-first: load 0xB4 -> 1,0,1,1,0,1,0,0. ser_last on the 8th beat.
- Lane width, WIDTH=8, LANES=2: load 0xB4 LSB-first -> beats 0,1,3,2; load 0xB4 MSB-first -> beats 2,3,1,0. 4 beats each, ser_last on the 4th.
- Back-to-back: hold in_valid=1 with 0x0F then 0xF0, LSB-first, LANES=1, ser_ready=1 -> 16 consecutive ser_valid cycles with no gap, bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1. in_ready pulses only on the two last beats. words_sent=2.
- Backpressure: drive ser_ready=0 for 3 cycles after the 2nd beat of 0xB4 (LSB-first) -> ser_data held at 0 and ser_last=0 for those 3 cycles, in_ready=0. The sequence then resumes 1,0,1,1,0,1 unchanged.
- Reset mid-word: assert rst for 1 cycle after the 3rd beat -> next cycle ser_valid=0, busy=0, words_sent=0, in_ready=1. The following load of 0x01 emits 1,0,0,0,0,0,0,0 with no residue from the aborted word.

Source files
------------

// File: rtl/shift_reg_serializer.sv
// ---------------------------------------------------------------------------
// shift_reg_serializer
// Parallel-in / serial-out shift register with valid/ready handshakes on both
// sides. It accepts a WIDTH-bit word and emits it as WIDTH/LANES beats of
// LANES bits each, LSB-first or MSB-first as chosen at accept time. It can
// stream words back to back with no bubble between them.
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   in_valid    producer has a word on in_data
//   in_ready    word accepted this cycle (combinational from ser_ready)
//   in_data     parallel word (WIDTH)
//   msb_first   beat order for the word being accepted
//   ser_valid   ser_data holds a valid beat
//   ser_ready   consumer accepts the beat
//   ser_data    current beat (LANES)
//   ser_last    current beat is the final beat of its word
//   busy        a word is in flight
//   words_sent  completed-word counter (CNT_W), wraps
// ---------------------------------------------------------------------------
module shift_reg_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic [LANES-1:0] ser_data,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Reject lane widths that do not divide the word evenly.
  if ((WIDTH % LANES) != 0) begin : g_width_check
    $error("shift_reg_serializer: WIDTH (%0d) must be a multiple of LANES (%0d)",
           WIDTH, LANES);
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic             msb_q;
  logic [CW-1:0]    beat_q;
  logic [CNT_W-1:0] words_q;
  logic             last_beat;
  logic             in_fire;
  logic             ser_fire;

  // Next-state and handshake decode. in_ready in SHIFT is a same-cycle
  // function of ser_ready so the next word loads on the last beat's edge.
  always_comb begin
    state_d   = state_q;
    ser_valid = 1'b0;
    in_ready  = 1'b0;
    last_beat = (state_q == SHIFT) && (beat_q == CW'(BEATS - 1));
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        in_ready  = !rst && ser_ready && last_beat;
        if (ser_ready && last_beat && !(in_valid && !rst)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign ser_fire = ser_valid && ser_ready;

  // State register plus datapath: load, shift, beat count, word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      msb_q   <= 1'b0;
      beat_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        sreg_q <= in_data;
        msb_q  <= msb_first;
        beat_q <= '0;
      end else if (ser_fire && !last_beat) begin
        sreg_q <= msb_q ? (sreg_q << LANES) : (sreg_q >> LANES);
        beat_q <= beat_q + CW'(1);
      end
      if (ser_fire && last_beat) begin
        words_q <= words_q + CNT_W'(1);
      end
    end
  end

  // Beat presentation; the active end of the register depends on order.
  always_comb begin
    ser_data = '0;
    if (state_q == SHIFT) begin
      ser_data = msb_q ? sreg_q[WIDTH-1 -: LANES] : sreg_q[LANES-1:0];
    end
  end

  assign ser_last   = last_beat;
  assign busy       = (state_q == SHIFT);
  assign words_sent = words_q;

endmodule

// File: tb/tb_shift_reg_serializer.sv
module tb_shift_reg_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LANES=1 instance
  logic        iv1, ir1, msb1, sv1, srdy1, sd1, sl1, busy1;
  logic [7:0]  din1;
  logic [15:0] ws1;

  // LANES=2 instance with a 2-bit word counter for wrap checking
  logic        iv2, ir2, msb2, sv2, srdy2, sl2, busy2;
  logic [7:0]  din2;
  logic [1:0]  sd2;
  logic [1:0]  ws2;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-computed beat sequences
  bit       b4_lsb[8]  = '{0, 0, 1, 0, 1, 1, 0, 1};
  bit       b4_msb[8]  = '{1, 0, 1, 1, 0, 1, 0, 0};
  bit       b2b_1[16]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  bit [1:0] b4_l2[4]   = '{2'd0, 2'd1, 2'd3, 2'd2};
  bit [1:0] b4_m2[4]   = '{2'd2, 2'd3, 2'd1, 2'd0};
  bit [1:0] b2b_2[8]   = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3};

  shift_reg_serializer #(.WIDTH(8), .LANES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .in_data(din1), .msb_first(msb1),
    .ser_valid(sv1), .ser_ready(srdy1), .ser_data(sd1), .ser_last(sl1),
    .busy(busy1), .words_sent(ws1)
  );

  shift_reg_serializer #(.WIDTH(8), .LANES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2), .in_data(din2), .msb_first(msb2),
    .ser_valid(sv2), .ser_ready(srdy2), .ser_data(sd2), .ser_last(sl2),
    .busy(busy2), .words_sent(ws2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  task automatic beat1(input string tag, input bit d, input bit l, input bit r);
    chk({tag, "_valid"}, 32'(sv1), 32'd1);
    chk({tag, "_data"},  32'(sd1), 32'(d));
    chk({tag, "_last"},  32'(sl1), 32'(l));
    chk({tag, "_ready"}, 32'(ir1), 32'(r));
  endtask

  task automatic beat2(input string tag, input bit [1:0] d, input bit l, input bit r);
    chk({tag, "_valid"}, 32'(sv2), 32'd1);
    chk({tag, "_data"},  32'(sd2), 32'(d));
    chk({tag, "_last"},  32'(sl2), 32'(l));
    chk({tag, "_ready"}, 32'(ir2), 32'(r));
  endtask

  initial begin
    rst = 1'b1;
    iv1 = 1'b0; din1 = '0; msb1 = 1'b0; srdy1 = 1'b1;
    iv2 = 1'b0; din2 = '0; msb2 = 1'b0; srdy2 = 1'b1;

    // Reset: in_ready forced low while rst, then clean idle state
    next(); #1;
    chk("rst_in_ready", 32'(ir1), 32'd0);
    next();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(sv1), 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_ws",    32'(ws1), 32'd0);
    chk("rst_data",  32'(sd1), 32'd0);
    chk("rst_last",  32'(sl1), 32'd0);
    chk("rst_ready", 32'(ir1), 32'd1);
    chk("rst2_data", 32'(sd2), 32'd0);

    // LSB-first 0xB4
    iv1 = 1'b1; din1 = 8'hB4; msb1 = 1'b0;
    next();
    iv1 = 1'b0; din1 = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      beat1($sformatf("lsb_b%0d", i), b4_lsb[i], i == 7, i == 7);
      chk("lsb_busy", 32'(busy1), 32'd1);
      next();
    end
    #1;
    chk("lsb_end_valid", 32'(sv1), 32'd0);
    chk("lsb_end_busy",  32'(busy1), 32'd0);
    chk("lsb_end_ws",    32'(ws1), 32'd1);

    // MSB-first 0xB4; msb_first flips mid-word and must not matter
    iv1 = 1'b1; din1 = 8'hB4; msb1 = 1'b1;
    next();
    iv1 = 1'b0; din1 = '0; msb1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      beat1($sformatf("msb_b%0d", i), b4_msb[i], i == 7, i == 7);
      next();
    end
    #1;
    chk("msb_end_ws", 32'(ws1), 32'd2);

    // Back-to-back 0x0F then 0xF0 with no bubble
    do_reset();
    iv1 = 1'b1; din1 = 8'h0F; msb1 = 1'b0;
    next();
    din1 = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      #1;
      beat1($sformatf("b2b_b%0d", i), b2b_1[i], (i == 7) || (i == 15), (i == 7) || (i == 15));
      if (i == 8) begin
        iv1 = 1'b0;
        din1 = '0;
      end
      next();
    end
    #1;
    chk("b2b_end_valid", 32'(sv1), 32'd0);
    chk("b2b_end_ws",    32'(ws1), 32'd2);

    // Backpressure on the 2nd beat of 0xB4
    iv1 = 1'b1; din1 = 8'hB4; msb1 = 1'b0;
    next();
    iv1 = 1'b0; din1 = '0;
    #1;
    beat1("bp_b0", 1'b0, 1'b0, 1'b0);
    next();
    srdy1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      beat1($sformatf("bp_stall%0d", k), 1'b0, 1'b0, 1'b0);
      next();
    end
    srdy1 = 1'b1;
    #1;
    beat1("bp_b1", 1'b0, 1'b0, 1'b0);
    next();
    for (int i = 2; i < 8; i++) begin
      #1;
      beat1($sformatf("bp_b%0d", i), b4_lsb[i], i == 7, i == 7);
      next();
    end
    #1;
    chk("bp_end_ws", 32'(ws1), 32'd3);

    // Reset after the 3rd beat discards the word
    iv1 = 1'b1; din1 = 8'hB4; msb1 = 1'b0;
    next();
    iv1 = 1'b0; din1 = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      beat1($sformatf("mr_b%0d", i), b4_lsb[i], 1'b0, 1'b0);
      next();
    end
    rst = 1'b1;
    #1;
    chk("mr_rst_ready", 32'(ir1), 32'd0);
    next();
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(sv1), 32'd0);
    chk("mr_busy",  32'(busy1), 32'd0);
    chk("mr_ws",    32'(ws1), 32'd0);
    chk("mr_ready", 32'(ir1), 32'd1);
    iv1 = 1'b1; din1 = 8'h01; msb1 = 1'b0;
    next();
    iv1 = 1'b0; din1 = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      beat1($sformatf("mr01_b%0d", i), i == 0, i == 7, i == 7);
      next();
    end
    #1;
    chk("mr01_ws", 32'(ws1), 32'd1);

    // LANES=2: LSB-first then MSB-first 0xB4
    do_reset();
    iv2 = 1'b1; din2 = 8'hB4; msb2 = 1'b0;
    next();
    iv2 = 1'b0; din2 = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      beat2($sformatf("l2_lsb_b%0d", i), b4_l2[i], i == 3, i == 3);
      next();
    end
    #1;
    chk("l2_lsb_busy", 32'(busy2), 32'd0);
    chk("l2_lsb_ws",   32'(ws2), 32'd1);
    iv2 = 1'b1; din2 = 8'hB4; msb2 = 1'b1;
    next();
    iv2 = 1'b0; din2 = '0; msb2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      beat2($sformatf("l2_msb_b%0d", i), b4_m2[i], i == 3, i == 3);
      next();
    end
    #1;
    chk("l2_msb_ws", 32'(ws2), 32'd2);

    // LANES=2 back-to-back; 2-bit counter wraps 3 -> 0
    iv2 = 1'b1; din2 = 8'h0F; msb2 = 1'b0;
    next();
    din2 = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      #1;
      beat2($sformatf("l2_b2b_b%0d", i), b2b_2[i], (i == 3) || (i == 7), (i == 3) || (i == 7));
      if (i == 4) begin
        chk("l2_wrap_mid_ws", 32'(ws2), 32'd3);
        iv2 = 1'b0;
        din2 = '0;
      end
      next();
    end
    #1;
    chk("l2_wrap_valid", 32'(sv2), 32'd0);
    chk("l2_wrap_ws",    32'(ws2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
